par2ser_stream: RTL and testbench

Parametrised parallel-to-serial converter with valid/ready handshakes on both sides.
- Accepts a WIDTH-bit word on the parallel side and emits it one bit per cycle on the serial side.
- Serial bit order is selectable. The serial side supports backpressure and frame markers.
- Sits between word-oriented datapaths and bit-serial links.
- Back-to-back words stream with no idle cycle between frames.

---
 rtl/par2ser_pkg.sv | 16 +
 rtl/p2s_shreg.sv | 34 +++
 rtl/par2ser_stream.sv | 88 ++++++++
 tb/tb_par2ser_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/par2ser_pkg.sv
// par2ser_stream shared types and helpers.
// FSM state encoding and counter width helper.
package par2ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2_min1(input int w);
    int r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/p2s_shreg.sv
// WIDTH-bit load/shift register with serial tap.
// Ports: clk, rst, load, shift, din[WIDTH], tap.
module p2s_shreg
  import par2ser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             tap
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      if (MSB_FIRST)
        q <= {q[WIDTH-2:0], 1'b0};
      else
        q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign tap = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter, valid/ready on both sides.
// Ports: in_data/in_valid/in_ready, ser_dout/valid/first/last/ready, busy.
module par2ser_stream
  import par2ser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_dout,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

  localparam int CNT_W = clog2_min1(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, xfer;
  logic             load, shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ser_valid <= (state_nxt == SHIFT);
      busy      <= (state_nxt == SHIFT);
      ser_first <= (state_nxt == SHIFT) &&
                   (cnt_nxt == '0);
      ser_last  <= (state_nxt == SHIFT) &&
                   (cnt_nxt == LAST);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept) state_nxt = SHIFT;
      SHIFT:
        if (xfer && ser_last && !accept)
          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    xfer     = ser_valid & ser_ready;
    in_ready = !rst &&
               ((state == IDLE) || (ser_last && xfer));
    accept   = in_valid & in_ready;
    load     = accept;
    shift    = xfer & ~ser_last;
    cnt_nxt  = cnt;
    if (load)
      cnt_nxt = '0;
    else if (shift)
      cnt_nxt = cnt + CNT_W'(1);
  end

  p2s_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_data),
    .tap   (ser_dout)
  );

endmodule

// File: tb/tb_par2ser_stream.sv
// Directed bench for par2ser_stream.
// Four instances: W4 MSB, W4 LSB, W5 MSB, W64 LSB.
module tb_par2ser_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] d4m = '0;
  logic v4m = 0, r4m = 1;
  logic ir4m, o4m, sv4m, sf4m, sl4m, b4m;

  logic [3:0] d4l = '0;
  logic v4l = 0, r4l = 1;
  logic ir4l, o4l, sv4l, sf4l, sl4l, b4l;

  logic [4:0] d5 = '0;
  logic v5 = 0, r5 = 1;
  logic ir5, o5, sv5, sf5, sl5, b5;

  logic [63:0] d64 = '0;
  logic v64 = 0, r64 = 0;
  logic ir64, o64, sv64, sf64, sl64, b64;

  par2ser_stream #(.WIDTH(4), .MSB_FIRST(1'b1)) u4m (
    .clk(clk), .rst(rst),
    .in_data(d4m), .in_valid(v4m), .in_ready(ir4m),
    .ser_dout(o4m), .ser_valid(sv4m),
    .ser_first(sf4m), .ser_last(sl4m),
    .ser_ready(r4m), .busy(b4m));

  par2ser_stream #(.WIDTH(4), .MSB_FIRST(1'b0)) u4l (
    .clk(clk), .rst(rst),
    .in_data(d4l), .in_valid(v4l), .in_ready(ir4l),
    .ser_dout(o4l), .ser_valid(sv4l),
    .ser_first(sf4l), .ser_last(sl4l),
    .ser_ready(r4l), .busy(b4l));

  par2ser_stream #(.WIDTH(5), .MSB_FIRST(1'b1)) u5 (
    .clk(clk), .rst(rst),
    .in_data(d5), .in_valid(v5), .in_ready(ir5),
    .ser_dout(o5), .ser_valid(sv5),
    .ser_first(sf5), .ser_last(sl5),
    .ser_ready(r5), .busy(b5));

  par2ser_stream #(.WIDTH(64), .MSB_FIRST(1'b0)) u64 (
    .clk(clk), .rst(rst),
    .in_data(d64), .in_valid(v64), .in_ready(ir64),
    .ser_dout(o64), .ser_valid(sv64),
    .ser_first(sf64), .ser_last(sl64),
    .ser_ready(r64), .busy(b64));

  initial begin
    logic [3:0]  w4;
    logic [7:0]  b2;
    logic [4:0]  w5;
    logic [63:0] q64 [$];
    logic [63:0] asm64, expw;
    int          k, nsent, nfirst, nlast, cyc;
    logic        x, a, f, l, dv;
    localparam int N64 = 4;

    // reset state
    repeat (2) tick();
    chk("rst_in_ready", ir4m, 0);
    chk("rst_valid", sv4m, 0);
    chk("rst_busy", b4m, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", ir4m, 1);
    chk("post_rst_in_ready64", ir64, 1);

    // W4 MSB first, 1011
    w4 = 4'b1011;
    d4m = w4; v4m = 1;
    tick();
    v4m = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_dout", o4m, w4[3-i]);
      chk("t1_valid", sv4m, 1);
      chk("t1_first", sf4m, (i == 0));
      chk("t1_last", sl4m, (i == 3));
      chk("t1_busy", b4m, 1);
      tick();
    end
    chk("t1_valid_drop", sv4m, 0);
    chk("t1_busy_drop", b4m, 0);
    chk("t1_in_ready", ir4m, 1);

    // W4 LSB first, back-to-back A then 3
    b2 = 8'b0011_1010;
    d4l = 4'hA; v4l = 1;
    tick();
    d4l = 4'h3;
    for (int i = 0; i < 8; i++) begin
      chk("t2_dout", o4l, b2[i]);
      chk("t2_valid", sv4l, 1);
      chk("t2_in_ready", ir4l, (i == 3 || i == 7));
      chk("t2_first", sf4l, (i == 0 || i == 4));
      tick();
      if (i == 3) v4l = 0;
    end
    chk("t2_valid_drop", sv4l, 0);

    // W5 with 3-cycle stall on bit 2
    w5 = 5'b10011;
    d5 = w5; v5 = 1;
    tick();
    v5 = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        r5 = 0;
        repeat (3) begin
          chk("t3_stall_dout", o5, 0);
          chk("t3_stall_valid", sv5, 1);
          chk("t3_stall_last", sl5, 0);
          chk("t3_stall_ir", ir5, 0);
          tick();
        end
        r5 = 1;
      end
      chk("t3_dout", o5, w5[4-i]);
      chk("t3_first", sf5, (i == 0));
      chk("t3_last", sl5, (i == 4));
      tick();
    end
    chk("t3_valid_drop", sv5, 0);

    // in_data toggled while shifting
    w4 = 4'b0110;
    d4m = w4; v4m = 1;
    tick();
    v4m = 0;
    for (int i = 0; i < 4; i++) begin
      d4m = 4'($urandom);
      chk("t5_dout", o4m, w4[3-i]);
      tick();
    end
    chk("t5_valid_drop", sv4m, 0);

    // reset mid-word
    d4m = 4'hF; v4m = 1;
    tick();
    v4m = 0;
    chk("t4_bit0", o4m, 1);
    tick();
    chk("t4_bit1", o4m, 1);
    tick();
    rst = 1;
    #1;
    chk("t4_rst_valid", sv4m, 0);
    chk("t4_rst_dout", o4m, 0);
    chk("t4_rst_first", sf4m, 0);
    chk("t4_rst_last", sl4m, 0);
    chk("t4_rst_busy", b4m, 0);
    chk("t4_rst_ir", ir4m, 0);
    tick();
    rst = 0;
    #1;
    chk("t4_rel_ir", ir4m, 1);
    chk("t4_rel_busy", b4m, 0);
    repeat (4) begin
      tick();
      chk("t4_no_stray", sv4m, 0);
    end

    // W64 random words, random backpressure
    k = 0; nsent = 0; nfirst = 0; nlast = 0;
    asm64 = '0;
    d64 = {$urandom, $urandom};
    v64 = 1;
    cyc = 0;
    while (nlast < N64 && cyc < 3000) begin
      r64 = 1'($urandom_range(0, 1));
      #1;
      x = sv64 & r64;
      a = v64 & ir64;
      dv = o64; f = sf64; l = sl64;
      tick();
      cyc++;
      if (x) begin
        asm64[k] = dv;
        if (f) nfirst++;
        if (k == 0) chk("t6_first", f, 1);
        if (l) begin
          nlast++;
          chk("t6_last_pos", k, 63);
          if (q64.size() > 0) expw = q64.pop_front();
          else expw = ~asm64;
          chk("t6_word", asm64, expw);
          k = 0;
        end else begin
          k++;
        end
      end
      if (a) begin
        q64.push_back(d64);
        nsent++;
        if (nsent < N64) d64 = {$urandom, $urandom};
        else v64 = 0;
      end
    end
    chk("t6_sent", nsent, N64);
    chk("t6_firsts", nfirst, N64);
    chk("t6_lasts", nlast, N64);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
